// File: rtl/beam_scan_pkg.sv
// Shared types and constants for the beam scan controller and its energy accumulator.
package beam_scan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      DWELL,
      COMPARE,
      NEXT,
      DONE
   } state_t;

   localparam int EN_HOLD_CYCLES = 4;
   localparam int ANGLE_W        = 5;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/beam_energy_acc.sv
// Per-direction energy accumulator: deviation from midscale, saturating sum.
// Define BEAM_SCAN_SQUARE_EN to accumulate squared deviation instead of absolute deviation.
module beam_energy_acc
   import beam_scan_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int ACC_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 add_en,
   input  logic [BIT_WIDTH-1:0] sample,
   output logic [ACC_W-1:0]     acc
);

`ifdef BEAM_SCAN_SQUARE_EN
   localparam int DEV_W = 2 * BIT_WIDTH;
`else
   localparam int DEV_W = BIT_WIDTH;
`endif
   // One spare bit above the wider operand so the overflow is visible before clamping.
   localparam int SUM_W = max_int(ACC_W, DEV_W) + 1;

   localparam logic [BIT_WIDTH-1:0] MID     = {1'b1, {(BIT_WIDTH-1){1'b0}}};
   localparam logic [SUM_W-1:0]     ACC_MAX = SUM_W'({ACC_W{1'b1}});

   logic [BIT_WIDTH-1:0] w_abs;
   logic [DEV_W-1:0]     w_dev;
   logic [SUM_W-1:0]     w_sum;
   logic [ACC_W-1:0]     r_acc;

   assign w_abs = (sample >= MID) ? (sample - MID) : (MID - sample);

`ifdef BEAM_SCAN_SQUARE_EN
   assign w_dev = DEV_W'(w_abs) * DEV_W'(w_abs);
`else
   assign w_dev = w_abs;
`endif

   assign w_sum = SUM_W'(r_acc) + SUM_W'(w_dev);

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (clear) begin
         r_acc <= '0;
      end else if (add_en) begin
         r_acc <= (w_sum > ACC_MAX) ? '1 : w_sum[ACC_W-1:0];
      end
   end

   assign acc = r_acc;

endmodule

// File: rtl/beam_scan_controller.sv
// Raster-sweeps beamformer steering, measures energy per direction, reports the strongest.
// Optional BEAM_SCAN_SQUARE_EN selects squared-deviation energy in beam_energy_acc.
module beam_scan_controller
   import beam_scan_pkg::*;
#(
   parameter int BIT_WIDTH     = 8,
   parameter int ANGLE_MIN     = -4,
   parameter int ANGLE_MAX     = 4,
   parameter int SETTLE_CYCLES = 300,
   parameter int DWELL_SAMPLES = 256,
   parameter int ACC_W         = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [BIT_WIDTH-1:0] beam_data_in,
   input  logic                 sample_valid,
   output logic                 steering_angle_en,
   output logic [ANGLE_W-1:0]   steering_angle_hori,
   output logic [ANGLE_W-1:0]   steering_angle_vert,
   output logic                 busy,
   output logic                 done,
   output logic [ANGLE_W-1:0]   best_hori,
   output logic [ANGLE_W-1:0]   best_vert,
   output logic [ACC_W-1:0]     best_energy
);

   localparam int CNT_W = $clog2(max_int(max_int(SETTLE_CYCLES, DWELL_SAMPLES), EN_HOLD_CYCLES)) + 1;

   localparam logic signed [ANGLE_W-1:0] A_MIN = ANGLE_W'(ANGLE_MIN);
   localparam logic signed [ANGLE_W-1:0] A_MAX = ANGLE_W'(ANGLE_MAX);
   localparam logic signed [ANGLE_W-1:0] A_ONE = ANGLE_W'(1);

   state_t                     r_state;
   logic [CNT_W-1:0]           r_cnt;
   logic                       r_en, r_busy, r_done;
   logic signed [ANGLE_W-1:0]  r_hori, r_vert;
   logic                       r_run_valid;
   logic [ACC_W-1:0]           r_run_energy;
   logic [ANGLE_W-1:0]         r_run_hori, r_run_vert;
   logic [ANGLE_W-1:0]         r_best_hori, r_best_vert;
   logic [ACC_W-1:0]           r_best_energy;
   logic [ACC_W-1:0]           w_acc;
   logic                       w_clear, w_add;

   assign w_clear = (r_state == SETTLE);
   assign w_add   = (r_state == DWELL) && sample_valid;

   beam_energy_acc #(
      .BIT_WIDTH (BIT_WIDTH),
      .ACC_W     (ACC_W)
   ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (w_clear),
      .add_en (w_add),
      .sample (beam_data_in),
      .acc    (w_acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_en          <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_hori        <= '0;
         r_vert        <= '0;
         r_run_valid   <= 1'b0;
         r_run_energy  <= '0;
         r_run_hori    <= '0;
         r_run_vert    <= '0;
         r_best_hori   <= '0;
         r_best_vert   <= '0;
         r_best_energy <= '0;
      end else if (abort) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state     <= APPLY;
                  r_cnt       <= '0;
                  r_en        <= 1'b1;
                  r_busy      <= 1'b1;
                  r_hori      <= A_MIN;
                  r_vert      <= A_MIN;
                  r_run_valid <= 1'b0;
               end
            end
            APPLY: begin
               if (r_cnt == CNT_W'(EN_HOLD_CYCLES - 1)) begin
                  r_state <= SETTLE;
                  r_cnt   <= '0;
                  r_en    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            SETTLE: begin
               if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                  r_state <= DWELL;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DWELL: begin
               if (sample_valid) begin
                  if (r_cnt == CNT_W'(DWELL_SAMPLES - 1)) begin
                     r_state <= COMPARE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            COMPARE: begin
               // Strict comparison: on a tie the earlier direction in the raster wins.
               if (!r_run_valid || (w_acc > r_run_energy)) begin
                  r_run_valid  <= 1'b1;
                  r_run_energy <= w_acc;
                  r_run_hori   <= r_hori;
                  r_run_vert   <= r_vert;
               end
               r_state <= NEXT;
            end
            NEXT: begin
               if (r_hori == A_MAX) begin
                  r_hori <= A_MIN;
                  if (r_vert == A_MAX) begin
                     r_state       <= DONE;
                     r_done        <= 1'b1;
                     r_best_hori   <= r_run_hori;
                     r_best_vert   <= r_run_vert;
                     r_best_energy <= r_run_energy;
                  end else begin
                     r_vert  <= r_vert + A_ONE;
                     r_state <= APPLY;
                     r_en    <= 1'b1;
                  end
               end else begin
                  r_hori  <= r_hori + A_ONE;
                  r_state <= APPLY;
                  r_en    <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_en    <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign steering_angle_en   = r_en;
   assign steering_angle_hori = r_hori;
   assign steering_angle_vert = r_vert;
   assign busy                = r_busy;
   assign done                = r_done;
   assign best_hori           = r_best_hori;
   assign best_vert           = r_best_vert;
   assign best_energy         = r_best_energy;

endmodule

// File: tb/tb_beam_scan_controller.sv
// Directed bench for beam_scan_controller: sweep timing, winner selection, abort, saturation.
module tb_beam_scan_controller;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int mode     = 0;

   // Main instance: 3x3 raster
   logic        start_a, abort_a, valid_a;
   logic [7:0]  data_a;
   logic        en_a, busy_a, done_a;
   logic [4:0]  hori_a, vert_a, bh_a, bv_a;
   logic [31:0] be_a;

   // Beamformer model: mode 1 makes (1,0) loud; mode 2 puts a large deviation only on invalid cycles.
   assign data_a = (mode == 1) ? (((hori_a == 5'd1) && (vert_a == 5'd0)) ? 8'd200 : 8'd128)
                 : (mode == 2) ? (valid_a ? 8'd200 : 8'd0)
                 : 8'd128;

   beam_scan_controller #(
      .BIT_WIDTH(8), .ANGLE_MIN(-1), .ANGLE_MAX(1),
      .SETTLE_CYCLES(8), .DWELL_SAMPLES(16), .ACC_W(32)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
      .beam_data_in(data_a), .sample_valid(valid_a),
      .steering_angle_en(en_a), .steering_angle_hori(hori_a), .steering_angle_vert(vert_a),
      .busy(busy_a), .done(done_a), .best_hori(bh_a), .best_vert(bv_a), .best_energy(be_a)
   );

   // Saturation instance: single direction, 8-bit accumulator
   logic       start_s;
   logic [7:0] data_s;
   logic       en_s, busy_s, done_s;
   logic [4:0] hori_s, vert_s, bh_s, bv_s;
   logic [7:0] be_s;

   beam_scan_controller #(
      .BIT_WIDTH(8), .ANGLE_MIN(0), .ANGLE_MAX(0),
      .SETTLE_CYCLES(4), .DWELL_SAMPLES(16), .ACC_W(8)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0),
      .beam_data_in(data_s), .sample_valid(1'b1),
      .steering_angle_en(en_s), .steering_angle_hori(hori_s), .steering_angle_vert(vert_s),
      .busy(busy_s), .done(done_s), .best_hori(bh_s), .best_vert(bv_s), .best_energy(be_s)
   );

   // Deviation-mode instance: single direction, input 138
   logic        start_q;
   logic [7:0]  data_q;
   logic        en_q, busy_q, done_q;
   logic [4:0]  hori_q, vert_q, bh_q, bv_q;
   logic [31:0] be_q;

   beam_scan_controller #(
      .BIT_WIDTH(8), .ANGLE_MIN(0), .ANGLE_MAX(0),
      .SETTLE_CYCLES(4), .DWELL_SAMPLES(16), .ACC_W(32)
   ) dut_q (
      .clk(clk), .rst_n(rst_n), .start(start_q), .abort(1'b0),
      .beam_data_in(data_q), .sample_valid(1'b1),
      .steering_angle_en(en_q), .steering_angle_hori(hori_q), .steering_angle_vert(vert_q),
      .busy(busy_q), .done(done_q), .best_hori(bh_q), .best_vert(bv_q), .best_energy(be_q)
   );

   // Runs one sweep on dut_a from a start pulse, monitoring busy/done/enable windows.
   task automatic run_sweep(input int inject_start_at, output int busy_cyc, output int done_cyc,
                            output int done_cnt, output int en_win, output int en_bad);
      int   c;
      int   run;
      logic prev_en;
      busy_cyc = 0; done_cyc = -1; done_cnt = 0; en_win = 0; en_bad = 0;
      run = 0; prev_en = 1'b0;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      c = 1;
      while (busy_a && c < 5000) begin
         busy_cyc++;
         if (done_a) begin
            done_cyc = c;
            done_cnt++;
         end
         if (en_a && !prev_en) begin
            en_win++;
            run = 0;
         end
         if (en_a) run++;
         if (!en_a && prev_en && run != 4) en_bad++;
         prev_en = en_a;
         valid_a = (mode == 2) ? ((c % 4) == 0) : 1'b1;
         start_a = (c == inject_start_at);
         @(posedge clk); #1;
         c++;
      end
      start_a = 1'b0;
      valid_a = 1'b1;
      n_checks++;
      if (busy_a !== 1'b0) begin
         n_errors++;
         $display("FAIL sweep_timeout: busy=%b after %0d cycles, required 0", busy_a, c);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; valid_a = 1'b1;
      start_s = 1'b0; data_s = 8'd255;
      start_q = 1'b0; data_q = 8'd138;
      #2;
      n_checks++;
      if ({en_a, hori_a, vert_a, busy_a, done_a, bh_a, bv_a, be_a} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: en=%b h=%h v=%h busy=%b done=%b bh=%h bv=%h be=%0d, required all 0",
                  en_a, hori_a, vert_a, busy_a, done_a, bh_a, bv_a, be_a);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({en_a, busy_a, done_a, be_a} !== '0) begin
         n_errors++;
         $display("FAIL reset_idle: en=%b busy=%b done=%b be=%0d, required 0", en_a, busy_a, done_a, be_a);
      end
   endtask

   task automatic test_flat_sweep();
      int bc, dc, dn, ew, eb;
      mode = 0;
      run_sweep(50, bc, dc, dn, ew, eb);
      n_checks++;
      if (bc !== 271) begin n_errors++; $display("FAIL flat_busy_cycles: got %0d required 271", bc); end
      n_checks++;
      if (dc !== 271 || dn !== 1) begin
         n_errors++; $display("FAIL flat_done: cycle %0d count %0d, required cycle 271 count 1", dc, dn);
      end
      n_checks++;
      if (bh_a !== 5'h1f || bv_a !== 5'h1f) begin
         n_errors++; $display("FAIL flat_best_angle: got (%h,%h) required (1f,1f)", bh_a, bv_a);
      end
      n_checks++;
      if (be_a !== 32'd0) begin n_errors++; $display("FAIL flat_best_energy: got %0d required 0", be_a); end
   endtask

   task automatic test_peak_sweep();
      int bc, dc, dn, ew, eb;
      mode = 1;
      run_sweep(-1, bc, dc, dn, ew, eb);
      n_checks++;
      if (bh_a !== 5'd1 || bv_a !== 5'd0) begin
         n_errors++; $display("FAIL peak_best_angle: got (%h,%h) required (01,00)", bh_a, bv_a);
      end
      n_checks++;
      if (be_a !== 32'd1152) begin n_errors++; $display("FAIL peak_best_energy: got %0d required 1152", be_a); end
      n_checks++;
      if (ew !== 9 || eb !== 0) begin
         n_errors++; $display("FAIL peak_en_windows: windows %0d bad %0d, required 9 and 0", ew, eb);
      end
      n_checks++;
      if (bc !== 271 || dc !== 271) begin
         n_errors++; $display("FAIL peak_timing: busy %0d done@%0d, required 271/271", bc, dc);
      end
   endtask

   task automatic test_abort();
      int found;
      int dn;
      found = 0;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         if (hori_a == 5'd0 && vert_a == 5'd0 && en_a) found = 1;
         else begin @(posedge clk); #1; end
      end
      n_checks++;
      if (found == 0) begin n_errors++; $display("FAIL abort_find_dir5: got 0 required 1"); end
      repeat (15) @(posedge clk);
      #1 abort_a = 1'b1;
      @(posedge clk); #1;
      abort_a = 1'b0;
      n_checks++;
      if (busy_a !== 1'b0 || en_a !== 1'b0 || done_a !== 1'b0) begin
         n_errors++; $display("FAIL abort_idle: busy=%b en=%b done=%b, required 0/0/0", busy_a, en_a, done_a);
      end
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done_a || busy_a) dn++;
      end
      n_checks++;
      if (dn !== 0) begin n_errors++; $display("FAIL abort_stays_idle: active cycles %0d required 0", dn); end
      n_checks++;
      if (bh_a !== 5'd1 || bv_a !== 5'd0 || be_a !== 32'd1152) begin
         n_errors++; $display("FAIL abort_best_kept: got (%h,%h,%0d) required (01,00,1152)", bh_a, bv_a, be_a);
      end
   endtask

   task automatic test_start_abort_idle();
      start_a = 1'b1; abort_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; abort_a = 1'b0;
      n_checks++;
      if (busy_a !== 1'b0 || en_a !== 1'b0) begin
         n_errors++; $display("FAIL start_abort_idle: busy=%b en=%b required 0/0", busy_a, en_a);
      end
      @(posedge clk); #1;
      n_checks++;
      if (busy_a !== 1'b0) begin n_errors++; $display("FAIL start_abort_later: busy=%b required 0", busy_a); end
   endtask

   task automatic test_sparse_valid();
      int bc, dc, dn, ew, eb;
      mode = 2;
      run_sweep(-1, bc, dc, dn, ew, eb);
      mode = 0;
      n_checks++;
      if (be_a !== 32'd1152) begin n_errors++; $display("FAIL sparse_energy: got %0d required 1152", be_a); end
      n_checks++;
      if (bh_a !== 5'h1f || bv_a !== 5'h1f) begin
         n_errors++; $display("FAIL sparse_tie_angle: got (%h,%h) required (1f,1f)", bh_a, bv_a);
      end
      n_checks++;
      if (bc < 676 || bc > 703 || dn !== 1) begin
         n_errors++; $display("FAIL sparse_busy: got %0d cycles %0d dones, required 676..703 and 1", bc, dn);
      end
   endtask

   task automatic test_saturation();
      int c;
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      c = 1;
      while (!done_s && c < 200) begin @(posedge clk); #1; c++; end
      n_checks++;
      if (c !== 27) begin n_errors++; $display("FAIL sat_done_cycle: got %0d required 27", c); end
      n_checks++;
      if (be_s !== 8'd255) begin n_errors++; $display("FAIL sat_energy: got %0d required 255", be_s); end
   endtask

   task automatic test_deviation_mode();
      int          c;
      logic [31:0] exp_e;
`ifdef BEAM_SCAN_SQUARE_EN
      exp_e = 32'd1600;
`else
      exp_e = 32'd160;
`endif
      start_q = 1'b1;
      @(posedge clk); #1;
      start_q = 1'b0;
      c = 1;
      while (!done_q && c < 200) begin @(posedge clk); #1; c++; end
      n_checks++;
      if (be_q !== exp_e || c !== 27) begin
         n_errors++; $display("FAIL dev_energy: got %0d at cycle %0d, required %0d at 27", be_q, c, exp_e);
      end
   endtask

   task automatic test_reset_midsweep();
      int dn;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (100) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({en_a, hori_a, vert_a, busy_a, done_a, bh_a, bv_a, be_a} !== '0) begin
         n_errors++;
         $display("FAIL midsweep_reset: en=%b busy=%b bh=%h bv=%h be=%0d, required all 0",
                  en_a, busy_a, bh_a, bv_a, be_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (done_a || busy_a) dn++;
      end
      n_checks++;
      if (dn !== 0) begin n_errors++; $display("FAIL midsweep_no_result: active cycles %0d required 0", dn); end
   endtask

   initial begin
      test_reset();
      test_flat_sweep();
      test_peak_sweep();
      test_abort();
      test_start_abort_idle();
      test_sparse_valid();
      test_saturation();
      test_deviation_mode();
      test_reset_midsweep();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/beam_scan_controller.md
Name: beam_scan_controller

Overview:
Sequences the delay-and-sum beamformer through a raster of steering directions. For each direction it:
- drives the steering angles and enable,
- waits for the delay lookup and shift lines to settle,
- accumulates output energy over a dwell window.

After the full sweep it reports the direction with the highest energy. It sits between the system control logic and the beamformer: its steering outputs feed the beamformer angle and enable inputs, and the beamformer summed output feeds back in.

Parameters:
- BIT_WIDTH, 8, width of beamformer output sample (unsigned, offset-binary, midscale 2^(BIT_WIDTH-1))
- ANGLE_MIN, -4, lowest steering index, both axes (signed, fits 5 bits)
- ANGLE_MAX, 4, highest steering index, both axes; must be >= ANGLE_MIN
- SETTLE_CYCLES, 300, clocks waited after enable before accumulating (>= 4)
- DWELL_SAMPLES, 256, number of sample_valid samples accumulated per direction (>= 1)
- ACC_W, 32, energy accumulator width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- abort  in  1  cancel sweep; returns to IDLE next cycle
- beam_data_in  in  BIT_WIDTH  beamformer summed output
- sample_valid  in  1  beam_data_in carries a new PCM-rate sample
- steering_angle_en  out  1  enable to beamformer (level; beamformer synchronises and edge-detects it)
- steering_angle_hori  out  5  horizontal steering index, two's complement
- steering_angle_vert  out  5  vertical steering index, two's complement
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion
- best_hori  out  5  winning horizontal index of last completed sweep
- best_vert  out  5  winning vertical index of last completed sweep
- best_energy  out  ACC_W  energy of winning direction

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - internal accumulator and running-best cleared;
  - running-best energy cleared to 0 with valid flag cleared.
- Async reset mid-sweep: immediate return to reset values; no partial result published.
- FSM states:
  - IDLE: busy=0, en=0.
    - start=1 → APPLY at next edge.
    - Angles load to (hori=ANGLE_MIN, vert=ANGLE_MIN).
    - Running best is invalidated.
  - APPLY: en=1 for exactly 4 cycles with angles stable, then → SETTLE.
  - SETTLE: en=0; count SETTLE_CYCLES clocks; accumulator cleared; then → DWELL.
  - DWELL: on each sample_valid=1 cycle:
    - acc += |beam_data_in − 2^(BIT_WIDTH-1)|, saturating at 2^ACC_W−1;
    - after DWELL_SAMPLES valid samples → COMPARE.
    - sample_valid=0 cycles neither count nor accumulate.
  - COMPARE (1 cycle):
    - if running best is invalid or acc > running best (strictly greater), capture acc and current angles.
    - Ties keep the earlier direction.
  - NEXT (1 cycle):
    - hori increments; at ANGLE_MAX it wraps to ANGLE_MIN and vert increments.
    - If (hori,vert) was (ANGLE_MAX,ANGLE_MAX) → DONE; else → APPLY.
  - DONE (1 cycle):
    - done=1; best_* registers load running best; → IDLE.
- busy=1 in every state except IDLE.
- Sweep order: vert outer, hori inner, ascending.
- Angles change only on NEXT and at IDLE exit, so they are stable throughout APPLY/SETTLE/DWELL.
- With sample_valid tied high, a direction costs 4 + SETTLE_CYCLES + DWELL_SAMPLES + 2 cycles.
- abort:
  - has priority over all transitions;
  - any non-IDLE state → IDLE next edge; en=0;
  - best_* keep the previous completed sweep values; done not pulsed.
- start while busy: ignored.
- start and abort asserted together in IDLE: abort wins; stay IDLE.
- The angle outputs are sign-extended from the signed counter to 5 bits.

Optional Feature:
- Macro: BEAM_SCAN_SQUARE_EN.
- Defined: DWELL accumulates the squared deviation (x − mid)², a BIT_WIDTH×BIT_WIDTH product, same saturation rule.
- Undefined: absolute deviation as above; no multiplier is inferred.

Decomposition:
- Package beam_scan_pkg:
  - state enum (IDLE, APPLY, SETTLE, DWELL, COMPARE, NEXT, DONE);
  - constant EN_HOLD_CYCLES=4;
  - angle width constant ANGLE_W=5.
- Sub-module beam_energy_acc holds the deviation (abs or square) plus the saturating accumulator.
  - Ports: clk, rst_n, clear, add_en, sample, acc.

Test Plan:
- ANGLE_MIN=-1, ANGLE_MAX=1, SETTLE_CYCLES=8, DWELL_SAMPLES=16, sample_valid=1, constant beam_data_in=128; start pulsed at edge 0 → done pulses in cycle 271, busy high cycles 1–271, best=(-1,-1), best_energy=0 (tie keeps first).
- Same configuration, model returns 200 only while angles=(hori=1,vert=0), else 128 → best_hori=1, best_vert=0, best_energy=16·72=1152; 9 distinct APPLY windows each with en high exactly 4 cycles.
- abort asserted during DWELL of the 5th direction after a prior completed sweep → IDLE next edge, busy=0, en=0, no done, best_* unchanged.
- sample_valid high every 4th cycle → DWELL lasts 64 cycles per direction; energy counts only valid samples.
- ACC_W=8, beam_data_in=255 → acc saturates at 255, never wraps.
- BIT_WIDTH=8, BEAM_SCAN_SQUARE_EN defined, input 138 for 16 samples → best_energy=1600.
